// File: rtl/ram_arb_pkg.sv
// Shared types and the rotating-priority search used by the RAM port arbiter.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package ram_arb_pkg;

    localparam int MAX_REQ = 4;
    localparam int PTR_W   = $clog2(MAX_REQ);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // First valid requester at or after ptr, wrapping modulo n; one-hot result.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] vld,
        input logic [PTR_W-1:0]   ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        logic [PTR_W-1:0]   slot;
        int                 idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            slot = idx[PTR_W-1:0];
            if ((k < n) && !found && vld[slot]) begin
                gnt[slot] = 1'b1;
                found     = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Pointer-rotated first-one finder: one-hot grant among NUM_REQ valid bits.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller masks req_vld to exclude ineligible requesters.
module rr_grant
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_vld,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic [MAX_REQ-1:0] vld_ext;
    logic [MAX_REQ-1:0] gnt_ext;
    logic               unused_gnt_hi;

    // Widen to the package width, search, and narrow back.
    always_comb begin
        vld_ext              = '0;
        vld_ext[NUM_REQ-1:0] = req_vld;
        gnt_ext              = rr_pick(vld_ext, ptr, NUM_REQ);
        gnt                  = gnt_ext[NUM_REQ-1:0];
    end

    // Upper grant bits are always zero when NUM_REQ < MAX_REQ.
    assign unused_gnt_hi = ^gnt_ext;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one read-first single-port RAM; RAM_ARB_LOCK_EN adds grant locking.
// Latency: grant and RAM pins combinational; read response one cycle after the accepting edge.
// Backpressure: req_ready is the one-hot grant; non-granted requesters hold their beat.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int  MEM_WIDTH = 32,
    parameter int  MEM_DEPTH = 1024,
    parameter int  NUM_REQ   = 2,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ-1:0]                 req_lock,
    input  logic [NUM_REQ-1:0][AW-1:0]         req_addr,
    input  logic [NUM_REQ-1:0][MEM_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [MEM_WIDTH-1:0]               rsp_data,
    output logic                               mem_enable,
    output logic                               mem_write_en,
    output logic                               mem_reset,
    output logic [AW-1:0]                      mem_address,
    output logic [MEM_WIDTH-1:0]               mem_data_in,
    input  logic [MEM_WIDTH-1:0]               mem_data_out
);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rsp_vld_q;
    logic               gnt_any;
    logic               gnt_write;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   gnt_idx_inc;

`ifdef RAM_ARB_LOCK_EN
    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   lock_id_q, lock_id_d;
    logic               gnt_lock;

    // While locked only the owner is eligible, even if it is idle this cycle.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && ((state_q == ARB) || (lock_id_q == PTR_W'(i)));
        end
    end

    assign gnt_lock = |(gnt & req_lock);

    // Lock FSM: enter on a locking beat, leave on the owner's first non-locking beat.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        ptr_d     = ptr_q;
        case (state_q)
            ARB: begin
                if (gnt_any) begin
                    ptr_d = gnt_idx_inc;
                    if (gnt_lock) begin
                        state_d   = LOCKED;
                        lock_id_d = gnt_idx;
                    end
                end
            end
            LOCKED: begin
                if (gnt_any && !gnt_lock) begin
                    state_d = ARB;
                    ptr_d   = gnt_idx_inc;
                end
            end
        endcase
    end

    // Lock state register; reset releases any held lock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end
`else
    logic unused_lock;

    assign unused_lock = ^req_lock;
    assign elig        = req_valid;

    // Plain round-robin: pointer moves past every accepted requester.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) ptr_d = gnt_idx_inc;
    end
`endif

    rr_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_grant (
        .req_vld (elig),
        .ptr     (ptr_q),
        .gnt     (gnt)
    );

    assign gnt_any     = |gnt;
    assign gnt_write   = |(gnt & req_write);
    assign gnt_idx_inc = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign req_ready   = gnt;

    // Encode the one-hot grant and steer the winner onto the RAM pins.
    always_comb begin
        gnt_idx     = '0;
        mem_address = '0;
        mem_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx     = PTR_W'(i);
                mem_address = req_addr[i];
                mem_data_in = req_wdata[i];
            end
        end
    end

    assign mem_enable   = gnt_any;
    assign mem_write_en = gnt_write;
    // Clearing the RAM output on writes makes rsp_data read back 0 after a write.
    assign mem_reset    = mem_enable & mem_write_en;

    // Priority pointer and read-response owner; reset drops any in-flight response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q     <= '0;
            rsp_vld_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rsp_vld_q <= gnt & ~req_write;
        end
    end

    assign rsp_valid = rsp_vld_q;
    assign rsp_data  = mem_data_out;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter (NUM_REQ=2 with a RAM model, NUM_REQ=3 grant order).
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_port_arbiter;

    localparam logic [31:0] DAT_W5 = 32'h3f020c49;
    localparam logic [31:0] DAT_A  = 32'h11111111;
    localparam logic [31:0] DAT_B  = 32'h22222222;

    logic              clock;
    logic              reset_n;

    logic [1:0]        req_valid, req_ready, req_write, req_lock, rsp_valid;
    logic [1:0][9:0]   req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [31:0]       rsp_data;
    logic              mem_enable, mem_write_en, mem_reset;
    logic [9:0]        mem_address;
    logic [31:0]       mem_data_in;
    logic [31:0]       mem_data_out;

    logic [2:0]        r3_valid, r3_ready, r3_rsp_valid;
    logic [2:0][9:0]   r3_addr;
    logic [2:0][31:0]  r3_wdata;
    logic [31:0]       r3_rsp_data;
    logic              r3_en, r3_we, r3_rst;
    logic [9:0]        r3_maddr;
    logic [31:0]       r3_mdin;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] ram [0:1023];

    ram_port_arbiter #(.MEM_WIDTH(32), .MEM_DEPTH(1024), .NUM_REQ(2)) u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_lock     (req_lock),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .mem_enable   (mem_enable),
        .mem_write_en (mem_write_en),
        .mem_reset    (mem_reset),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    ram_port_arbiter #(.MEM_WIDTH(32), .MEM_DEPTH(1024), .NUM_REQ(3)) u_dut3 (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (r3_valid),
        .req_ready    (r3_ready),
        .req_write    (3'b000),
        .req_lock     (3'b000),
        .req_addr     (r3_addr),
        .req_wdata    (r3_wdata),
        .rsp_valid    (r3_rsp_valid),
        .rsp_data     (r3_rsp_data),
        .mem_enable   (r3_en),
        .mem_write_en (r3_we),
        .mem_reset    (r3_rst),
        .mem_address  (r3_maddr),
        .mem_data_in  (r3_mdin),
        .mem_data_out (32'h0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Read-first single-port RAM with registered output, cleared on write cycles.
    always @(posedge clock) begin
        if (mem_enable) begin
            mem_data_out <= mem_reset ? 32'h0 : ram[mem_address];
            if (mem_write_en) ram[mem_address] <= mem_data_in;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic l,
                           input logic [9:0] a, input logic [31:0] d);
        req_valid[i] = v;
        req_write[i] = w;
        req_lock[i]  = l;
        req_addr[i]  = a;
        req_wdata[i] = d;
    endtask

    logic [1:0] ctab [4];
    logic [1:0] dgnt [5];
    logic       dv1  [5];
    logic       dl1  [5];
    logic [2:0] v3   [8];
    logic [2:0] g3   [8];

    initial begin
        reset_n   = 1'b0;
        req_valid = '0; req_write = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        r3_valid  = '0; r3_addr = '0; r3_wdata = '0;

        // Reset state
        #2;
        check("rst_ready",  req_ready,    2'b00);
        check("rst_rspv",   rsp_valid,    2'b00);
        check("rst_en",     mem_enable,   1'b0);
        check("rst_we",     mem_write_en, 1'b0);
        check("rst_mrst",   mem_reset,    1'b0);
        check("rst_addr",   mem_address,  10'd0);
        #5;
        reset_n = 1'b1;

        // Write 5 then read 5 from requester 0
        set_req(0, 1'b1, 1'b1, 1'b0, 10'd5, DAT_W5);
        #1;
        check("wr_ready",   req_ready,    2'b01);
        check("wr_en",      mem_enable,   1'b1);
        check("wr_we",      mem_write_en, 1'b1);
        check("wr_mrst",    mem_reset,    1'b1);
        check("wr_addr",    mem_address,  10'd5);
        check("wr_din",     mem_data_in,  DAT_W5);
        tick();
        set_req(0, 1'b1, 1'b0, 1'b0, 10'd5, 32'h0);
        #1;
        check("wr_no_rsp",  rsp_valid,    2'b00);
        check("wr_dout0",   mem_data_out, 32'h0);
        check("rd_ready",   req_ready,    2'b01);
        check("rd_we",      mem_write_en, 1'b0);
        check("rd_mrst",    mem_reset,    1'b0);
        tick();
        req_valid = '0;
        #1;
        check("rd_rspv",    rsp_valid,    2'b01);
        check("rd_data",    rsp_data,     DAT_W5);
        tick();
        check("rd_rsp_1cyc", rsp_valid,   2'b00);

        // ptr=1: simultaneous writes, requester 1 first
        set_req(0, 1'b1, 1'b1, 1'b0, 10'd1, DAT_A);
        set_req(1, 1'b1, 1'b1, 1'b0, 10'd2, DAT_B);
        #1;
        check("bw_gnt1",    req_ready,    2'b10);
        check("bw_addr1",   mem_address,  10'd2);
        check("bw_din1",    mem_data_in,  DAT_B);
        tick();
        req_valid[1] = 1'b0;
        #1;
        check("bw_gnt0",    req_ready,    2'b01);
        check("bw_addr0",   mem_address,  10'd1);
        tick();
        req_valid = '0;

        // Continuous reads from both: grants alternate, responses follow grant order
        ctab = '{2'b10, 2'b01, 2'b10, 2'b01};
        set_req(0, 1'b1, 1'b0, 1'b0, 10'd1, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 10'd2, 32'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("alt_gnt%0d", c), req_ready, ctab[c]);
            if (c > 0) begin
                check($sformatf("alt_rspv%0d", c), rsp_valid, ctab[c-1]);
                check($sformatf("alt_data%0d", c), rsp_data, (ctab[c-1] == 2'b01) ? DAT_A : DAT_B);
            end
            tick();
        end
        req_valid = '0;
        #1;
        check("alt_rspv4",  rsp_valid,    ctab[3]);
        check("alt_data4",  rsp_data,     DAT_A);
        tick();

        // Requester 1 beats with req_lock while requester 0 waits (ptr=1 here)
        dv1 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        dl1 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef RAM_ARB_LOCK_EN
        dgnt = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b01};
`else
        dgnt = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
`endif
        for (int c = 0; c < 5; c++) begin
            set_req(0, 1'b1, 1'b0, 1'b0, 10'd1, 32'h0);
            set_req(1, dv1[c], 1'b0, dl1[c], 10'd2, 32'h0);
            #1;
            check($sformatf("lock_gnt%0d", c), req_ready, dgnt[c]);
            tick();
        end
        req_valid = '0; req_lock = '0;

        // Read accepted, then reset pulsed before the response is consumed (ptr=1 here)
        set_req(0, 1'b1, 1'b0, 1'b0, 10'd1, 32'h0);
        #1;
        check("rr_gnt",     req_ready,    2'b01);
        tick();
        req_valid = '0;
        #1;
        check("rr_rspv_pre", rsp_valid,   2'b01);
        reset_n = 1'b0;
        #1;
        check("rr_rspv_rst", rsp_valid,   2'b00);
        reset_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b0, 10'd1, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 10'd2, 32'h0);
        #1;
        check("rr_gnt_post", req_ready,   2'b01);
        tick();
        req_valid = '0;
        #1;
        check("rr_ram_kept", rsp_data,    DAT_A);
        tick();

        // NUM_REQ=3: all valid, then requester 1 drops out
        v3 = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b101, 3'b101, 3'b101};
        g3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b001};
        for (int c = 0; c < 8; c++) begin
            r3_valid = v3[c];
            #1;
            check($sformatf("n3_gnt%0d", c), r3_ready, g3[c]);
            tick();
        end
        r3_valid = '0;
        #1;
        check("n3_idle",    r3_en,        1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
